// File: rtl/axi_tg_pkg.sv
// axi_tg_pkg: FSM state, AXI constants, clog2 and pattern helpers for axi_full_burst_tester
//   AXI_TG_LFSR_PATTERN_EN selects the Galois LFSR pattern instead of the incrementing one.
package axi_tg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_DONE} tg_state_e;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
`ifdef AXI_TG_LFSR_PATTERN_EN
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
`endif
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic logic [31:0] pattern_seed(input logic [31:0] s);
`ifdef AXI_TG_LFSR_PATTERN_EN
    return (s == 32'd0) ? 32'd1 : s;
`else
    return s;
`endif
  endfunction
  function automatic logic [31:0] pattern_step(input logic [31:0] w);
`ifdef AXI_TG_LFSR_PATTERN_EN
    return {1'b0, w[31:1]} ^ (w[0] ? LFSR_POLY : 32'd0);
`else
    return w + 32'd1;
`endif
  endfunction
endpackage

// File: rtl/axi_full_burst_tester_pattern_gen.sv
// axi_tg_pattern_gen: pattern word generator, replicated across the data bus with lane index in the top byte
//   clk/rst_n clock and async active-low reset; load restarts from seed; step advances one beat; value is the bus-wide word.
module axi_tg_pattern_gen
  import axi_tg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hA5A5_0000,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  output logic [DW-1:0] value
);
  logic [31:0] word;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) word <= pattern_seed(SEED);
    else if (load) word <= pattern_seed(SEED);
    else if (step) word <= pattern_step(word);
  for (genvar k = 0; k < DW / 32; k++) begin : g_lane
    assign value[32*k +: 32] = word ^ {8'(k), 24'd0};
  end
endmodule

// File: rtl/axi_full_burst_tester.sv
// axi_full_burst_tester: AXI4-full master that writes NUM_BURSTS INCR bursts then reads and checks them
//   Ports: M_AXI_ACLK/M_AXI_ARESETN clock and async active-low reset; i_start starts a pass;
//   o_busy/o_done/o_error/o_err_cnt/o_led status; M_AXI_AW/W/B/AR/R full AXI4 master channels.
//   AXI_TG_LFSR_PATTERN_EN selects the LFSR data pattern.
module axi_full_burst_tester
  import axi_tg_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int C_M_AXI_BURST_LEN = 16,
  parameter int C_NUM_BURSTS = 4,
  parameter int C_M_AXI_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_PATTERN_SEED = 32'hA5A5_0000,
  parameter int C_ERR_CNT_WIDTH = 8
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error,
  output logic [C_ERR_CNT_WIDTH-1:0]      o_err_cnt,
  output logic                            o_led,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWLOCK,
  output logic [3:0]                      M_AXI_AWCACHE,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [3:0]                      M_AXI_AWQOS,
  output logic                            M_AXI_AWUSER,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WUSER,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic                            M_AXI_ARUSER,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int BW = clog2(C_NUM_BURSTS + 1);
  localparam int LW = clog2(C_M_AXI_BURST_LEN + 1);
  localparam logic [BW-1:0] LAST_BURST = BW'(C_NUM_BURSTS - 1);
  localparam logic [LW-1:0] LAST_BEAT = LW'(C_M_AXI_BURST_LEN - 1);
  localparam logic [AW-1:0] BURST_BYTES = AW'(C_M_AXI_BURST_LEN * BYTES);
  tg_state_e state, nxt;
  logic [BW-1:0] burst;
  logic [LW-1:0] beat;
  logic [AW-1:0] axi_addr;
  logic [DW-1:0] wr_data, rd_exp;
  logic start_go, w_hs, b_hs, r_hs, last_beat, last_burst, fault, unused_ids;
  assign start_go = i_start && (state == S_IDLE || state == S_DONE);
  assign w_hs = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs = M_AXI_BVALID && M_AXI_BREADY;
  assign r_hs = M_AXI_RVALID && M_AXI_RREADY;
  assign last_beat = beat == LAST_BEAT;
  assign last_burst = burst == LAST_BURST;
  assign unused_ids = ^{M_AXI_BID, M_AXI_RID};
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (i_start) nxt = S_WA;
      S_WA: if (M_AXI_AWREADY) nxt = S_WD;
      S_WD: if (w_hs && last_beat) nxt = S_WB;
      S_WB: if (M_AXI_BVALID) nxt = last_burst ? S_RA : S_WA;
      S_RA: if (M_AXI_ARREADY) nxt = S_RD;
      S_RD: if (r_hs && last_beat) nxt = last_burst ? S_DONE : S_RA;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    M_AXI_AWVALID = state == S_WA;
    M_AXI_WVALID = state == S_WD;
    M_AXI_WLAST = state == S_WD && last_beat;
    M_AXI_BREADY = state == S_WB;
    M_AXI_ARVALID = state == S_RA;
    M_AXI_RREADY = state == S_RD;
    o_done = state == S_DONE;
    o_busy = !(state == S_IDLE || state == S_DONE);
  end
  // Beat count follows accepted beats, not RLAST, so an early RLAST cannot cut a burst short.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      burst <= '0;
      beat <= '0;
    end else begin
      if (start_go) burst <= '0;
      else if (b_hs || (r_hs && last_beat)) burst <= last_burst ? '0 : burst + 1'b1;
      if (w_hs || r_hs) beat <= last_beat ? '0 : beat + 1'b1;
    end
  assign fault = (b_hs && M_AXI_BRESP != AXI_RESP_OKAY) ||
                 (r_hs && (M_AXI_RRESP != AXI_RESP_OKAY || M_AXI_RDATA != rd_exp || M_AXI_RLAST != last_beat));
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      o_error <= 1'b0;
      o_err_cnt <= '0;
    end else if (start_go) begin
      o_error <= 1'b0;
      o_err_cnt <= '0;
    end else if (fault) begin
      o_error <= 1'b1;
      if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
    end
  assign o_led = o_done && !o_error;
  // Separate generators keep write and check paths independent; the checker restarts when reads begin.
  axi_tg_pattern_gen #(.SEED(C_PATTERN_SEED), .DW(DW)) u_wr_pat (
    .clk(M_AXI_ACLK), .rst_n(M_AXI_ARESETN), .load(start_go), .step(w_hs), .value(wr_data)
  );
  axi_tg_pattern_gen #(.SEED(C_PATTERN_SEED), .DW(DW)) u_rd_pat (
    .clk(M_AXI_ACLK), .rst_n(M_AXI_ARESETN), .load(start_go || (b_hs && last_burst)), .step(r_hs), .value(rd_exp)
  );
  assign axi_addr = AW'(C_M_TARGET_SLAVE_BASE_ADDR) + BURST_BYTES * AW'(burst);
  assign M_AXI_AWID = '0;
  assign M_AXI_AWADDR = axi_addr;
  assign M_AXI_AWLEN = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_AWSIZE = 3'(clog2(BYTES));
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWLOCK = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_AWQOS = 4'd0;
  assign M_AXI_AWUSER = 1'b0;
  assign M_AXI_WDATA = wr_data;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_WUSER = 1'b0;
  assign M_AXI_ARID = '0;
  assign M_AXI_ARADDR = axi_addr;
  assign M_AXI_ARLEN = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_ARSIZE = 3'(clog2(BYTES));
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARLOCK = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_ARQOS = 4'd0;
  assign M_AXI_ARUSER = 1'b0;
endmodule

// File: tb/tb_axi_full_burst_tester.sv
// tb_axi_full_burst_tester: randomized slave-driven checks of axi_full_burst_tester against a spec-level pattern model
module tb_axi_full_burst_tester;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] SEED = 32'hA5A5_0000;
  localparam int EW = 5;
  logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_start_1 = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic busy, done, error, led;
  logic [EW-1:0] err_cnt;
  logic awid, awlock, awuser, awvalid, awready, wlast, wuser, wvalid, wready, bvalid, bready;
  logic arid, arlock, aruser, arvalid, arready, rlast, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] awcache, arcache, awqos, arqos, wstrb;
  axi_full_burst_tester #(.C_ERR_CNT_WIDTH(EW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .i_start(i_start),
    .o_busy(busy), .o_done(done), .o_error(error), .o_err_cnt(err_cnt), .o_led(led),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
    .M_AXI_AWQOS(awqos), .M_AXI_AWUSER(awuser), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WUSER(wuser),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(1'b0), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
    .M_AXI_ARQOS(arqos), .M_AXI_ARUSER(aruser), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(1'b0), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );
  logic busy_1, done_1, error_1, led_1;
  logic [7:0] err_cnt_1;
  logic awid_1, awlock_1, awuser_1, awvalid_1, wlast_1, wuser_1, wvalid_1, bvalid_1, bready_1;
  logic arid_1, arlock_1, aruser_1, arvalid_1, rlast_1, rvalid_1, rready_1;
  logic [31:0] awaddr_1, araddr_1, wdata_1, rdata_1;
  logic [7:0] awlen_1, arlen_1;
  logic [2:0] awsize_1, arsize_1, awprot_1, arprot_1;
  logic [1:0] awburst_1, arburst_1;
  logic [3:0] awcache_1, arcache_1, awqos_1, arqos_1, wstrb_1;
  axi_full_burst_tester #(.C_M_AXI_BURST_LEN(1), .C_NUM_BURSTS(3)) dut_1 (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .i_start(i_start_1),
    .o_busy(busy_1), .o_done(done_1), .o_error(error_1), .o_err_cnt(err_cnt_1), .o_led(led_1),
    .M_AXI_AWID(awid_1), .M_AXI_AWADDR(awaddr_1), .M_AXI_AWLEN(awlen_1), .M_AXI_AWSIZE(awsize_1),
    .M_AXI_AWBURST(awburst_1), .M_AXI_AWLOCK(awlock_1), .M_AXI_AWCACHE(awcache_1), .M_AXI_AWPROT(awprot_1),
    .M_AXI_AWQOS(awqos_1), .M_AXI_AWUSER(awuser_1), .M_AXI_AWVALID(awvalid_1), .M_AXI_AWREADY(1'b1),
    .M_AXI_WDATA(wdata_1), .M_AXI_WSTRB(wstrb_1), .M_AXI_WLAST(wlast_1), .M_AXI_WUSER(wuser_1),
    .M_AXI_WVALID(wvalid_1), .M_AXI_WREADY(1'b1),
    .M_AXI_BID(1'b0), .M_AXI_BRESP(2'b00), .M_AXI_BVALID(bvalid_1), .M_AXI_BREADY(bready_1),
    .M_AXI_ARID(arid_1), .M_AXI_ARADDR(araddr_1), .M_AXI_ARLEN(arlen_1), .M_AXI_ARSIZE(arsize_1),
    .M_AXI_ARBURST(arburst_1), .M_AXI_ARLOCK(arlock_1), .M_AXI_ARCACHE(arcache_1), .M_AXI_ARPROT(arprot_1),
    .M_AXI_ARQOS(arqos_1), .M_AXI_ARUSER(aruser_1), .M_AXI_ARVALID(arvalid_1), .M_AXI_ARREADY(1'b1),
    .M_AXI_RID(1'b0), .M_AXI_RDATA(rdata_1), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(rlast_1),
    .M_AXI_RVALID(rvalid_1), .M_AXI_RREADY(rready_1)
  );
  function automatic logic [31:0] exp_word(input int n);
`ifdef AXI_TG_LFSR_PATTERN_EN
    logic [31:0] s = (SEED == 32'd0) ? 32'd1 : SEED;
    for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
`else
    return SEED + 32'(n);
`endif
  endfunction
  logic [31:0] mem [64];
  logic [31:0] aw_log [$], ar_log [$];
  int aw_n = 0, w_n = 0, ar_n = 0, r_n = 0, drop_n = 0, proto_n = 0;
  int wbeat, rsent, corrupt_idx = -1;
  logic stall = 1'b0, corrupt_all = 1'b0, bad_bresp0 = 1'b0, clr_mem = 1'b0;
  logic [31:0] w_addr, r_addr, pv_awaddr, pv_araddr, pv_wdata;
  logic pv_aw, pv_ar, pv_w, r_act;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00; rlast <= 1'b0; r_act <= 1'b0;
      pv_aw <= 1'b0; pv_ar <= 1'b0; pv_w <= 1'b0; wbeat <= 0; rsent <= 0; w_addr <= BASE; r_addr <= BASE;
    end else begin
      if (clr_mem) for (int i = 0; i < 64; i++) mem[i] <= '0;
      if ((pv_aw && (!awvalid || awaddr !== pv_awaddr)) || (pv_ar && (!arvalid || araddr !== pv_araddr)) ||
          (pv_w && (!wvalid || wdata !== pv_wdata))) drop_n <= drop_n + 1;
      pv_aw <= awvalid && !awready; pv_awaddr <= awaddr;
      pv_ar <= arvalid && !arready; pv_araddr <= araddr;
      pv_w <= wvalid && !wready; pv_wdata <= wdata;
      awready <= stall ? 1'($urandom) : 1'b1;
      wready <= stall ? 1'($urandom) : 1'b1;
      arready <= stall ? 1'($urandom) : 1'b1;
      if (awvalid && awready) begin
        aw_n <= aw_n + 1; aw_log.push_back(awaddr); w_addr <= awaddr; wbeat <= 0;
        if (awlen !== 8'd15 || awsize !== 3'd2 || awburst !== 2'b01 || awcache !== 4'b0011) proto_n <= proto_n + 1;
      end
      if (wvalid && wready) begin
        mem[int'((w_addr - BASE) >> 2) + wbeat] <= wdata;
        w_n <= w_n + 1; wbeat <= wbeat + 1;
        if (wlast !== (wbeat == 15) || wstrb !== 4'hf) proto_n <= proto_n + 1;
        if (wbeat == 15) begin
          bvalid <= 1'b1;
          bresp <= (bad_bresp0 && w_addr == BASE) ? 2'b10 : 2'b00;
        end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_n <= ar_n + 1; ar_log.push_back(araddr); r_addr <= araddr; rsent <= 0; r_act <= 1'b1;
        if (arlen !== 8'd15 || arsize !== 3'd2 || arburst !== 2'b01) proto_n <= proto_n + 1;
      end
      if (rvalid && rready) r_n <= r_n + 1;
      if (r_act && (!rvalid || rready)) begin
        if (rsent == 16) begin
          rvalid <= 1'b0; r_act <= 1'b0;
        end else if (!stall || 1'($urandom)) begin
          rvalid <= 1'b1; rlast <= rsent == 15; rsent <= rsent + 1;
          rdata <= mem[int'((r_addr - BASE) >> 2) + rsent] ^
                   ((corrupt_all || int'((r_addr - BASE) >> 2) + rsent == corrupt_idx) ? 32'h0000_0100 : 32'h0);
        end else rvalid <= 1'b0;
      end
    end
  end
  logic [31:0] mem1 [4];
  logic [31:0] aw_log1 [$];
  logic [31:0] waddr1;
  int w_n1 = 0, wl_n1 = 0, r_n1 = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_1 <= 1'b0; rvalid_1 <= 1'b0; rdata_1 <= '0; rlast_1 <= 1'b0; waddr1 <= BASE;
    end else begin
      if (awvalid_1) begin aw_log1.push_back(awaddr_1); waddr1 <= awaddr_1; end
      if (wvalid_1) begin
        mem1[(waddr1 - BASE) >> 2] <= wdata_1; w_n1 <= w_n1 + 1; bvalid_1 <= 1'b1;
        if (wlast_1) wl_n1 <= wl_n1 + 1;
      end
      if (bvalid_1 && bready_1) bvalid_1 <= 1'b0;
      if (arvalid_1) begin
        rvalid_1 <= 1'b1; rlast_1 <= 1'b1; rdata_1 <= mem1[(araddr_1 - BASE) >> 2];
      end else if (rvalid_1 && rready_1) begin
        rvalid_1 <= 1'b0; r_n1 <= r_n1 + 1;
      end
    end
  end
  function automatic int mem_errs();
    int e = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_word(i)) e++;
    return e;
  endfunction
  function automatic int addr_errs(input int from);
    int e = 0;
    for (int b = 0; b < 4; b++) begin
      if (aw_log.size() <= from + b || aw_log[from + b] !== BASE + 32'(b * 64)) e++;
      if (ar_log.size() <= from + b || ar_log[from + b] !== BASE + 32'(b * 64)) e++;
    end
    return e;
  endfunction
  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 5000) begin @(negedge clk); t++; end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s_timeout: o_done=%0b required 1", tag, done); end
  endtask
  task automatic pulse_start;
    @(negedge clk); i_start = 1'b1; @(negedge clk); i_start = 1'b0;
  endtask
  task automatic wipe;
    @(negedge clk); clr_mem = 1'b1; @(negedge clk); clr_mem = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, led, err_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_status: busy/done/error/led/cnt=%b required 0", {busy, done, error, led, err_cnt});
    end
    n_cmp++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_handshake: aw/w/b/ar/r=%b required 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
  endtask
  task automatic test_basic;
    int a0 = aw_n, w0 = w_n, ar0 = ar_n, r0 = r_n, l0 = aw_log.size();
    wipe();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: o_busy=%0b required 1", busy); end
    wait_done("basic");
    n_cmp++;
    if (aw_n - a0 != 4 || w_n - w0 != 64 || ar_n - ar0 != 4 || r_n - r0 != 64) begin
      n_bad++; $display("FAIL basic_counts: aw=%0d w=%0d ar=%0d r=%0d required 4/64/4/64", aw_n - a0, w_n - w0, ar_n - ar0, r_n - r0);
    end
    n_cmp++;
    if ({done, error, err_cnt, led, busy} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL basic_status: done=%0b error=%0b cnt=%0d led=%0b busy=%0b required 1/0/0/1/0", done, error, err_cnt, led, busy);
    end
    n_cmp++;
    if (mem_errs() != 0) begin n_bad++; $display("FAIL basic_data: %0d bad words required 0", mem_errs()); end
    n_cmp++;
    if (addr_errs(l0) != 0) begin n_bad++; $display("FAIL basic_addr: %0d bad addresses required 0", addr_errs(l0)); end
    n_cmp++;
    if (proto_n != 0) begin n_bad++; $display("FAIL basic_protocol: %0d violations required 0", proto_n); end
  endtask
  task automatic test_stall;
    int a0 = aw_n, l0 = aw_log.size();
    stall = 1'b1;
    wipe();
    pulse_start();
    repeat (30) @(negedge clk);
    i_start = 1'b1; @(negedge clk); i_start = 1'b0;
    wait_done("stall");
    stall = 1'b0;
    n_cmp++;
    if (aw_n - a0 != 4) begin n_bad++; $display("FAIL stall_ignore_start: aw=%0d required 4", aw_n - a0); end
    n_cmp++;
    if (mem_errs() != 0) begin n_bad++; $display("FAIL stall_data: %0d bad words required 0", mem_errs()); end
    n_cmp++;
    if (drop_n != 0) begin n_bad++; $display("FAIL stall_valid_drop: %0d drops required 0", drop_n); end
    n_cmp++;
    if ({error, err_cnt, led} !== {1'b0, 5'd0, 1'b1}) begin
      n_bad++; $display("FAIL stall_status: error=%0b cnt=%0d led=%0b required 0/0/1", error, err_cnt, led);
    end
    n_cmp++;
    if (addr_errs(l0) != 0 || proto_n != 0) begin
      n_bad++; $display("FAIL stall_addr: %0d bad addr, %0d protocol required 0/0", addr_errs(l0), proto_n);
    end
  endtask
  task automatic test_corrupt;
    int ar0 = ar_n, r0 = r_n;
    corrupt_idx = 2 * 16 + 5;
    pulse_start();
    wait_done("corrupt");
    corrupt_idx = -1;
    n_cmp++;
    if ({error, err_cnt, led} !== {1'b1, 5'd1, 1'b0}) begin
      n_bad++; $display("FAIL corrupt_status: error=%0b cnt=%0d led=%0b required 1/1/0", error, err_cnt, led);
    end
    n_cmp++;
    if (ar_n - ar0 != 4 || r_n - r0 != 64) begin
      n_bad++; $display("FAIL corrupt_all_bursts: ar=%0d r=%0d required 4/64", ar_n - ar0, r_n - r0);
    end
  endtask
  task automatic test_saturate;
    corrupt_all = 1'b1; bad_bresp0 = 1'b1;
    pulse_start();
    wait_done("saturate");
    corrupt_all = 1'b0; bad_bresp0 = 1'b0;
    n_cmp++;
    if ({error, err_cnt, led} !== {1'b1, 5'd31, 1'b0}) begin
      n_bad++; $display("FAIL saturate_cnt: error=%0b cnt=%0d led=%0b required 1/31/0", error, err_cnt, led);
    end
    pulse_start();
    wait_done("restart_clear");
    n_cmp++;
    if ({error, err_cnt, led} !== {1'b0, 5'd0, 1'b1}) begin
      n_bad++; $display("FAIL restart_clear: error=%0b cnt=%0d led=%0b required 0/0/1", error, err_cnt, led);
    end
  endtask
  task automatic test_reset_mid;
    int t = 0;
    pulse_start();
    while (!wvalid && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wvalid !== 1'b1) begin n_bad++; $display("FAIL midreset_in_wd: wvalid=%0b required 1", wvalid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, done, error, err_cnt} !== '0) begin
      n_bad++; $display("FAIL midreset_async: valids/status=%b required 0", {awvalid, wvalid, bready, arvalid, rready, busy, done, error, err_cnt});
    end
    @(negedge clk); rst_n = 1'b1;
    wipe();
    pulse_start();
    wait_done("midreset_pass");
    n_cmp++;
    if ({error, err_cnt, led} !== {1'b0, 5'd0, 1'b1} || mem_errs() != 0) begin
      n_bad++; $display("FAIL midreset_clean: error=%0b cnt=%0d led=%0b badwords=%0d required 0/0/1/0", error, err_cnt, led, mem_errs());
    end
  endtask
  task automatic test_len1;
    int t = 0, e = 0;
    @(negedge clk); i_start_1 = 1'b1; @(negedge clk); i_start_1 = 1'b0;
    while (!done_1 && t < 500) begin @(negedge clk); t++; end
    n_cmp++;
    if (!done_1) begin n_bad++; $display("FAIL len1_timeout: o_done=%0b required 1", done_1); end
    for (int b = 0; b < 3; b++) if (aw_log1.size() <= b || aw_log1[b] !== BASE + 32'(b * 4)) e++;
    n_cmp++;
    if (e != 0 || aw_log1.size() != 3) begin
      n_bad++; $display("FAIL len1_addr: %0d bad of %0d required 0 of 3", e, aw_log1.size());
    end
    n_cmp++;
    if (w_n1 != 3 || wl_n1 != 3) begin n_bad++; $display("FAIL len1_wlast: w=%0d wlast=%0d required 3/3", w_n1, wl_n1); end
    e = 0;
    for (int i = 0; i < 3; i++) if (mem1[i] !== exp_word(i)) e++;
    n_cmp++;
    if (e != 0 || r_n1 != 3) begin n_bad++; $display("FAIL len1_data: %0d bad words, r=%0d required 0/3", e, r_n1); end
    n_cmp++;
    if ({error_1, err_cnt_1, led_1} !== {1'b0, 8'd0, 1'b1}) begin
      n_bad++; $display("FAIL len1_status: error=%0b cnt=%0d led=%0b required 0/0/1", error_1, err_cnt_1, led_1);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_corrupt();
    test_saturate();
    test_len1();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
